trap_controller: RTL
====================

// Module: trap_controller
// PURPOSE
//   Consumes trapped/trap_status from the exception detector and sequences M-mode trap entry and MRET return.
//   Drives a single-port CSR write interface (mepc, mcause, mtval, mstatus) and reads mtvec/mepc/mstatus.
//   Stalls the pipeline while it runs and issues a one-cycle PC redirect to the fetch stage.
//   Direct-mode mtvec only. No interrupts.
// PARAMETERS
//   XLEN             32  datapath / CSR width
//   CAUSE_MISALIGNED 0   mcause value for instruction-address-misaligned
//   CAUSE_EBREAK     3   mcause value for breakpoint
//   CAUSE_ECALL      11  mcause value for ECALL from M-mode
// PORTS
//   clk              in   1     core clock, all state updates on rising edge
//   reset_n          in   1     asynchronous, active-low reset
//   trapped          in   1     exception detector: trap request this cycle
//   trap_status      in   2     00 ECALL, 01 EBREAK, 10 MISALIGNED, 11 MRET
//   pc               in   XLEN  PC of the trapping instruction
//   fault_address    in   XLEN  misaligned branch/jump target (used for mtval)
//   csr_read_data    in   XLEN  combinational read data for csr_read_address
//   csr_read_address out  12    CSR address being read
//   csr_write_enable out  1     CSR write strobe, one write per cycle
//   csr_write_address out 12    CSR write address
//   csr_write_data   out  XLEN  CSR write data
//   trap_stall       out  1     hold PC and pipeline registers
//   redirect_valid   out  1     one-cycle pulse: fetch next from redirect_target
//   redirect_target  out  XLEN  new PC, bits [1:0] always 00
// BEHAVIOUR
//   Reset: state IDLE; latched pc/status/fault cleared. All outputs 0 while reset_n=0. Reset mid-sequence aborts; remaining CSR writes are not issued.
//   IDLE: trapped=1 latches pc, trap_status and fault_address.
//     status 11 -> M_MSTATUS; otherwise -> E_MEPC.
//   Exception path (one state per cycle, csr_write_enable=1 in the first four):
//     E_MEPC    write 0x341 <= latched pc
//     E_MCAUSE  write 0x342 <= CAUSE_* selected by latched status
//     E_MTVAL   write 0x343 <= fault_address (MISALIGNED), pc (EBREAK), 0 (ECALL)
//     E_MSTATUS read 0x300; write 0x300 <= rd with MPIE(7)=rd[3], MIE(3)=0, MPP(12:11)=11
//     E_VECTOR  read 0x305; redirect_valid=1, target={rd[31:2],2'b00}; -> IDLE
//   MRET path:
//     M_MSTATUS read 0x300; write 0x300 <= rd with MIE=rd[7], MPIE=1, MPP=11
//     M_RETURN  read 0x341; redirect_valid=1, target={rd[31:2],2'b00}; -> IDLE
//   trap_stall = trapped (in IDLE) OR state!=IDLE, so it is high from the detect cycle through the redirect cycle.
//   Latency, detect to redirect: exception 5 cycles, MRET 2 cycles. Redirect occurs in the last state.
//   trapped is ignored outside IDLE; no queuing. A trap asserted in the cycle after the redirect starts a fresh sequence.
//   trap_status 11 with trapped=0 does nothing.
//   When csr_write_enable=0: write address and data are 0. csr_read_address is 0 outside read states.
//   CSR bits not named above pass through from csr_read_data unchanged.
// TESTING
//   ECALL at pc=0x100, mtvec=0x200, mstatus=0x8 -> writes mepc=0x100, mcause=11, mtval=0, mstatus=0x1880; redirect_valid, target 0x200 on cycle 5.
//   MISALIGNED at pc=0x80, fault_address=0xF1 -> mcause=0, mtval=0xF1; trap_stall high 6 cycles, including detect.
//   EBREAK at pc=0x3C, mtvec=0x203 -> mcause=3, mtval=0x3C; redirect_target=0x200, low bits masked.
//   MRET with mepc=0x104, mstatus=0x1880 -> mstatus write 0x1888; redirect 0x104 on cycle 2; no other writes.
//   trapped re-pulsed during E_MCAUSE -> ignored; exactly one 4-write sequence and one redirect.
//   reset_n low during E_MTVAL -> all outputs 0 immediately; no mstatus write after release; IDLE.

Source files
------------

// File: rtl/trap_controller.sv
// M-mode trap entry / MRET sequencer: walks the CSR update sequence one write per cycle,
// stalls the pipeline meanwhile and finishes with a single-cycle PC redirect.
module trap_controller #(
   parameter int unsigned XLEN             = 32,
   parameter int unsigned CAUSE_MISALIGNED = 0,
   parameter int unsigned CAUSE_EBREAK     = 3,
   parameter int unsigned CAUSE_ECALL      = 11
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            trapped,
   input  logic [1:0]      trap_status,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] fault_address,
   input  logic [XLEN-1:0] csr_read_data,
   output logic [11:0]     csr_read_address,
   output logic            csr_write_enable,
   output logic [11:0]     csr_write_address,
   output logic [XLEN-1:0] csr_write_data,
   output logic            trap_stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_target
);

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMtvec   = 12'h305;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;
   localparam logic [11:0] CsrMtval   = 12'h343;

   localparam logic [1:0] StatEcall  = 2'b00;
   localparam logic [1:0] StatEbreak = 2'b01;
   localparam logic [1:0] StatMisal  = 2'b10;
   localparam logic [1:0] StatMret   = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StEMepc,
      StEMcause,
      StEMtval,
      StEMstatus,
      StEVector,
      StMMstatus,
      StMReturn
   } state_e;

   state_e          state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fault_q;
   logic [1:0]      status_q;
   logic            we_q;
   logic [11:0]     waddr_q;
   logic [11:0]     raddr_q;
   logic            redir_q;

   // Strobes and addresses are registered as a function of the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         pc_q     <= '0;
         fault_q  <= '0;
         status_q <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         raddr_q  <= '0;
         redir_q  <= 1'b0;
      end else begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         raddr_q <= '0;
         redir_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (trapped) begin
                  pc_q     <= pc;
                  fault_q  <= fault_address;
                  status_q <= trap_status;
                  we_q     <= 1'b1;
                  if (trap_status == StatMret) begin
                     state_q <= StMMstatus;
                     waddr_q <= CsrMstatus;
                     raddr_q <= CsrMstatus;
                  end else begin
                     state_q <= StEMepc;
                     waddr_q <= CsrMepc;
                  end
               end
            end
            StEMepc: begin
               state_q <= StEMcause;
               we_q    <= 1'b1;
               waddr_q <= CsrMcause;
            end
            StEMcause: begin
               state_q <= StEMtval;
               we_q    <= 1'b1;
               waddr_q <= CsrMtval;
            end
            StEMtval: begin
               state_q <= StEMstatus;
               we_q    <= 1'b1;
               waddr_q <= CsrMstatus;
               raddr_q <= CsrMstatus;
            end
            StEMstatus: begin
               state_q <= StEVector;
               raddr_q <= CsrMtvec;
               redir_q <= 1'b1;
            end
            StMMstatus: begin
               state_q <= StMReturn;
               raddr_q <= CsrMepc;
               redir_q <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic [XLEN-1:0] cause;
   logic [XLEN-1:0] mtval;
   logic [XLEN-1:0] mstatus_entry;
   logic [XLEN-1:0] mstatus_mret;

   always_comb begin
      cause = XLEN'(CAUSE_MISALIGNED);
      mtval = '0;
      case (status_q)
         StatEcall:  cause = XLEN'(CAUSE_ECALL);
         StatEbreak: begin
            cause = XLEN'(CAUSE_EBREAK);
            mtval = pc_q;
         end
         StatMisal:  mtval = fault_q;
         default:    ;
      endcase

      mstatus_entry        = csr_read_data;
      mstatus_entry[7]     = csr_read_data[3];
      mstatus_entry[3]     = 1'b0;
      mstatus_entry[12:11] = 2'b11;

      mstatus_mret         = csr_read_data;
      mstatus_mret[3]      = csr_read_data[7];
      mstatus_mret[7]      = 1'b1;
      mstatus_mret[12:11]  = 2'b11;

      csr_write_data = '0;
      case (state_q)
         StEMepc:    csr_write_data = pc_q;
         StEMcause:  csr_write_data = cause;
         StEMtval:   csr_write_data = mtval;
         StEMstatus: csr_write_data = mstatus_entry;
         StMMstatus: csr_write_data = mstatus_mret;
         default:    csr_write_data = '0;
      endcase
   end

   assign csr_write_enable  = we_q;
   assign csr_write_address = waddr_q;
   assign csr_read_address  = raddr_q;
   assign redirect_valid    = redir_q;
   assign redirect_target   = redir_q ? {csr_read_data[XLEN-1:2], 2'b00} : '0;
   // reset_n gate keeps the stall low during reset even if the detector still asserts trapped.
   assign trap_stall        = (state_q != StIdle) | (trapped & reset_n);

endmodule
